// File: rtl/global_controller_if.sv
// global_controller_if: AXI4-Lite slave port bundle for the global controller register block.
interface global_controller_if #(parameter int DW = 32, parameter int AW = 12);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic            bvalid;
  logic [1:0]      bresp;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;
  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bvalid, bresp, arready, rdata, rresp, rvalid
  );
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input  awready, wready, bvalid, bresp, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/global_controller.sv
// global_controller: AXI4-Lite register block holding ID/SCRATCH/STALL/START/STATUS/IER for the CGRA.
module global_controller #(
  parameter int AXI_DWIDTH = 32,
  parameter int AXI_AWIDTH = 12
) (
  input  logic                clk,
  input  logic                reset,
  global_controller_if.slave  bus,
  output logic [3:0]          glb_stall,
  output logic                cgra_start,
  input  logic                cgra_done,
  output logic                irq
);
  localparam int DW = AXI_DWIDTH;
  localparam int AW = AXI_AWIDTH;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  w_state_t        r_wstate, w_wnext;
  r_state_t        r_rstate, w_rnext;
  logic [31:0]     r_scratch;
  logic [3:0]      r_stall;
  logic            r_status, r_ier, r_start;
  logic [1:0]      r_bresp, r_rresp;
  logic [DW-1:0]   r_rdata;
  logic [DW-1:0]   w_mask;
  logic [31:0]     w_rval;
  logic [2:0]      w_widx, w_ridx;
  logic            w_whs, w_rhs, w_wmap, w_rmap, w_we, w_b0, w_unused;
  for (genvar i = 0; i < DW/8; i++) begin : g_mask
    assign w_mask[8*i +: 8] = {8{bus.wstrb[i]}};
  end
  assign w_widx   = bus.awaddr[4:2];
  assign w_ridx   = bus.araddr[4:2];
  assign w_wmap   = (bus.awaddr[AW-1:5] == '0) && (w_widx < 3'd6);
  assign w_rmap   = (bus.araddr[AW-1:5] == '0) && (w_ridx < 3'd6);
  // Both channels must be valid together; the write commits on that single edge.
  assign w_whs    = !reset && (r_wstate == W_IDLE) && bus.awvalid && bus.wvalid;
  assign w_rhs    = bus.arready && bus.arvalid;
  assign w_we     = w_whs && w_wmap;
  assign w_b0     = bus.wstrb[0] && bus.wdata[0];
  assign bus.awready = w_whs;
  assign bus.wready  = w_whs;
  assign bus.bvalid  = (r_wstate == W_RESP);
  assign bus.bresp   = r_bresp;
  assign bus.arready = !reset && (r_rstate == R_IDLE);
  assign bus.rvalid  = (r_rstate == R_RESP);
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = r_rresp;
  assign glb_stall   = r_stall;
  assign cgra_start  = r_start;
  assign irq         = r_status && r_ier;
  assign w_unused    = &{1'b0, bus.awprot, bus.arprot, bus.awaddr[1:0], bus.araddr[1:0]};
  always_comb begin
    w_wnext = (r_wstate == W_IDLE) ? (w_whs ? W_RESP : W_IDLE) : (bus.bready ? W_IDLE : W_RESP);
    w_rnext = (r_rstate == R_IDLE) ? (w_rhs ? R_RESP : R_IDLE) : (bus.rready ? R_IDLE : R_RESP);
    w_rval  = !w_rmap        ? 32'h0 :
              w_ridx == 3'd0 ? 32'h474C_4301 :
              w_ridx == 3'd1 ? r_scratch :
              w_ridx == 3'd2 ? {28'h0, r_stall} :
              w_ridx == 3'd4 ? {31'h0, r_status} :
              w_ridx == 3'd5 ? {31'h0, r_ier} : 32'h0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scratch <= '0;
      r_stall   <= 4'hF;
      r_status  <= 1'b0;
      r_ier     <= 1'b0;
      r_start   <= 1'b0;
      r_bresp   <= 2'b00;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
    end else begin
      if (w_we && w_widx == 3'd1) r_scratch <= (bus.wdata[31:0] & w_mask[31:0]) | (r_scratch & ~w_mask[31:0]);
      if (w_we && w_widx == 3'd2 && bus.wstrb[0]) r_stall <= bus.wdata[3:0];
      if (w_we && w_widx == 3'd5 && bus.wstrb[0]) r_ier <= bus.wdata[0];
      // A done event in the clearing cycle wins, so no completion is lost.
      r_status <= cgra_done || (r_status && !(w_we && w_widx == 3'd4 && w_b0));
      r_start  <= w_we && w_widx == 3'd3 && w_b0;
      if (w_whs) r_bresp <= w_wmap ? 2'b00 : 2'b10;
      if (w_rhs) begin
        r_rdata <= DW'(w_rval);
        r_rresp <= w_rmap ? 2'b00 : 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_global_controller.sv
// tb_global_controller: randomized self-checking bench against a register-map reference model.
module tb_global_controller;
  logic       clk = 0;
  logic       reset = 1;
  logic [3:0] glb_stall;
  logic       cgra_start;
  logic       cgra_done = 0;
  logic       irq;
  int         n_tests = 0;
  int         n_fail = 0;
  int         start_cnt = 0;
  logic [31:0] m_scratch;
  logic [3:0]  m_stall;
  logic        m_status, m_ier;
  global_controller_if #(.DW(32), .AW(12)) bus();
  global_controller #(.AXI_DWIDTH(32), .AXI_AWIDTH(12)) dut (
    .clk(clk), .reset(reset), .bus(bus), .glb_stall(glb_stall),
    .cgra_start(cgra_start), .cgra_done(cgra_done), .irq(irq)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (cgra_start) start_cnt++;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_scratch = 0; m_stall = 4'hF; m_status = 0; m_ier = 0;
  endtask

  task automatic model_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    if (a[11:5] != 0 || a[4:2] > 5) return;
    case (a[4:2])
      3'd1: for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
      3'd2: if (s[0]) m_stall = d[3:0];
      3'd4: if (s[0] && d[0]) m_status = 0;
      3'd5: if (s[0]) m_ier = d[0];
      default: ;
    endcase
  endtask

  function automatic void exp_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    if (a[11:5] != 0 || a[4:2] > 5) begin d = 0; r = 2'b10; return; end
    r = 2'b00;
    case (a[4:2])
      3'd0: d = 32'h474C_4301;
      3'd1: d = m_scratch;
      3'd2: d = {28'h0, m_stall};
      3'd4: d = {31'h0, m_status};
      3'd5: d = {31'h0, m_ier};
      default: d = 0;
    endcase
  endfunction

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    int n = 0;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s; bus.awprot = 3'($urandom);
    bus.awvalid = 1; bus.wvalid = 1;
    #1;
    while (!(bus.awready && bus.wready) && n < 50) begin @(posedge clk); #2; n++; end
    if (n >= 50) begin n_tests++; n_fail++; $display("FAIL aw_timeout addr=%h", a); end
    @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    model_write(a, d, s);
    n_tests++;
    if (bus.bvalid !== 1'b1) begin n_fail++; $display("FAIL b_latency bvalid=%b want 1", bus.bvalid); end
    resp = bus.bresp;
    bus.bready = 1;
    @(posedge clk); #1;
    bus.bready = 0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    bus.araddr = a; bus.arprot = 3'($urandom); bus.arvalid = 1;
    #1;
    while (!bus.arready && n < 50) begin @(posedge clk); #2; n++; end
    if (n >= 50) begin n_tests++; n_fail++; $display("FAIL ar_timeout addr=%h", a); end
    @(posedge clk); #1;
    bus.arvalid = 0;
    n_tests++;
    if (bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL r_latency rvalid=%b want 1", bus.rvalid); end
    d = bus.rdata; resp = bus.rresp;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    n_tests++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== d) begin n_fail++; $display("FAIL r_hold rvalid=%b rdata=%h want 1/%h", bus.rvalid, bus.rdata, d); end
    bus.rready = 1;
    @(posedge clk); #1;
    bus.rready = 0;
  endtask

  task automatic check_read(input string nm, input logic [11:0] a);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    exp_read(a, ed, er);
    axi_read(a, d, r);
    n_tests++;
    if (d !== ed || r !== er) begin
      n_fail++; $display("FAIL %s addr=%h rdata=%h rresp=%b want %h/%b", nm, a, d, r, ed, er);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, cgra_start, irq} !== 7'b0 ||
        bus.bresp !== 2'b00 || bus.rresp !== 2'b00 || bus.rdata !== 32'h0 || glb_stall !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_state aw=%b w=%b b=%b ar=%b r=%b st=%b irq=%b stall=%h rdata=%h",
               bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, cgra_start, irq, glb_stall, bus.rdata);
    end
    reset = 0;
    model_reset();
    #1;
    n_tests++;
    if (bus.arready !== 1'b1) begin n_fail++; $display("FAIL arready_after_reset got=%b want 1", bus.arready); end
    @(posedge clk); #1;
  endtask

  task automatic test_id_stall();
    check_read("read_id", 12'h000);
    check_read("read_stall_reset", 12'h008);
    check_read("read_status_reset", 12'h010);
  endtask

  task automatic test_scratch_strobe();
    logic [1:0] r1, r2;
    axi_write(12'h004, 32'hDEAD_BEEF, 4'hF, r1);
    axi_write(12'h004, 32'h0000_0012, 4'b0001, r2);
    n_tests++;
    if (r1 !== 2'b00 || r2 !== 2'b00) begin n_fail++; $display("FAIL scratch_bresp got=%b,%b want 00,00", r1, r2); end
    n_tests++;
    if (m_scratch !== 32'hDEAD_BE12) begin n_fail++; $display("FAIL scratch_model got=%h want deadbe12", m_scratch); end
    check_read("scratch_strobe", 12'h004);
    check_read("scratch_unaligned", 12'h007);
  endtask

  task automatic test_unmapped();
    logic [1:0] r;
    axi_write(12'h100, 32'h1234_5678, 4'hF, r);
    n_tests++;
    if (r !== 2'b10) begin n_fail++; $display("FAIL unmapped_bresp got=%b want 10", r); end
    check_read("unmapped_read", 12'h100);
    axi_write(12'h018, 32'hFFFF_FFFF, 4'hF, r);
    n_tests++;
    if (r !== 2'b10) begin n_fail++; $display("FAIL hole_bresp got=%b want 10", r); end
    axi_write(12'h000, 32'h0, 4'hF, r);
    n_tests++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL id_write_bresp got=%b want 00", r); end
    check_read("id_after_write", 12'h000);
  endtask

  task automatic test_backpressure();
    logic [1:0] r;
    bus.awaddr = 12'h004; bus.wdata = 32'h1111_2222; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1;
    #1; @(posedge clk); #1;
    model_write(12'h004, 32'h1111_2222, 4'hF);
    bus.wdata = 32'h3333_4444;
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold cyc=%0d bvalid=%b awready=%b want 1/0", k, bus.bvalid, bus.awready);
      end
      @(posedge clk); #1;
    end
    bus.bready = 1;
    @(posedge clk); #1;
    bus.bready = 0;
    n_tests++;
    if (bus.awready !== 1'b1) begin n_fail++; $display("FAIL bp_accept awready=%b want 1", bus.awready); end
    @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    model_write(12'h004, 32'h3333_4444, 4'hF);
    r = bus.bresp;
    bus.bready = 1;
    @(posedge clk); #1;
    bus.bready = 0;
    n_tests++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL bp_bresp got=%b want 00", r); end
    check_read("bp_scratch", 12'h004);
  endtask

  task automatic test_irq();
    logic [1:0] r;
    axi_write(12'h014, 32'h1, 4'hF, r);
    cgra_done = 1;
    @(posedge clk); #1;
    cgra_done = 0;
    m_status = 1;
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got=%b want 1", irq); end
    check_read("status_set", 12'h010);
    axi_write(12'h010, 32'h1, 4'hF, r);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got=%b want 0", irq); end
    bus.awaddr = 12'h010; bus.wdata = 32'h1; bus.wstrb = 4'hF;
    bus.awvalid = 1; bus.wvalid = 1; cgra_done = 1;
    #1; @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0; cgra_done = 0;
    m_status = 1;
    bus.bready = 1;
    @(posedge clk); #1;
    bus.bready = 0;
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins got=%b want 1", irq); end
    check_read("status_set_wins", 12'h010);
    axi_write(12'h014, 32'h0, 4'hF, r);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked got=%b want 0", irq); end
  endtask

  task automatic test_start();
    logic [1:0] r;
    int c0;
    bus.awaddr = 12'h00C; bus.wdata = 32'h1; bus.wstrb = 4'h1;
    bus.awvalid = 1; bus.wvalid = 1;
    #1;
    n_tests++;
    if (cgra_start !== 1'b0) begin n_fail++; $display("FAIL start_early got=%b want 0", cgra_start); end
    @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    n_tests++;
    if (cgra_start !== 1'b1) begin n_fail++; $display("FAIL start_pulse got=%b want 1", cgra_start); end
    @(posedge clk); #1;
    n_tests++;
    if (cgra_start !== 1'b0) begin n_fail++; $display("FAIL start_width got=%b want 0", cgra_start); end
    bus.bready = 1;
    @(posedge clk); #1;
    bus.bready = 0;
    c0 = start_cnt;
    axi_write(12'h00C, 32'h1, 4'hE, r);
    axi_write(12'h00C, 32'hFFFF_FFFE, 4'hF, r);
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (start_cnt !== c0) begin n_fail++; $display("FAIL start_masked pulses=%0d want 0", start_cnt - c0); end
    check_read("start_reads_zero", 12'h00C);
    axi_write(12'h008, 32'hFFFF_FFF0, 4'hF, r);
    n_tests++;
    if (glb_stall !== 4'h0) begin n_fail++; $display("FAIL stall_zero got=%h want 0", glb_stall); end
  endtask

  task automatic test_concurrent();
    logic [31:0] old, nd;
    logic [1:0]  br;
    old = m_scratch;
    nd = $urandom;
    bus.awaddr = 12'h004; bus.wdata = nd; bus.wstrb = 4'hF; bus.awvalid = 1; bus.wvalid = 1;
    bus.araddr = 12'h004; bus.arvalid = 1;
    #1; @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    model_write(12'h004, nd, 4'hF);
    n_tests++;
    if (bus.rvalid !== 1'b1 || bus.bvalid !== 1'b1 || bus.rdata !== old) begin
      n_fail++; $display("FAIL concurrent rvalid=%b bvalid=%b rdata=%h want 1/1/%h", bus.rvalid, bus.bvalid, bus.rdata, old);
    end
    br = bus.bresp;
    bus.bready = 1; bus.rready = 1;
    @(posedge clk); #1;
    bus.bready = 0; bus.rready = 0;
    n_tests++;
    if (br !== 2'b00) begin n_fail++; $display("FAIL concurrent_bresp got=%b want 00", br); end
    check_read("concurrent_new", 12'h004);
  endtask

  task automatic test_random();
    logic [11:0] a;
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    logic [3:0]  s;
    for (int k = 0; k < 60; k++) begin
      a = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(8, 1023) * 4) : 12'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom);
        exp_read(a, ed, er);
        axi_write(a, d, s, r);
        n_tests++;
        if (r !== er) begin n_fail++; $display("FAIL rand_bresp addr=%h got=%b want %b", a, r, er); end
      end else begin
        exp_read(a, ed, er);
        axi_read(a, d, r);
        n_tests++;
        if (d !== ed || r !== er) begin n_fail++; $display("FAIL rand_read addr=%h got=%h/%b want %h/%b", a, d, r, ed, er); end
      end
      n_tests++;
      if (irq !== (m_status & m_ier) || glb_stall !== m_stall) begin
        n_fail++; $display("FAIL rand_outputs irq=%b stall=%h want %b/%h", irq, glb_stall, m_status & m_ier, m_stall);
      end
    end
  endtask

  task automatic test_reset_abort();
    bus.awaddr = 12'h004; bus.wdata = 32'hA5A5_A5A5; bus.wstrb = 4'hF; bus.awvalid = 1; bus.wvalid = 1;
    bus.araddr = 12'h000; bus.arvalid = 1;
    #1; @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
    reset = 1;
    @(posedge clk); #1;
    n_tests++;
    if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0) begin
      n_fail++; $display("FAIL abort_pending bvalid=%b rvalid=%b want 0/0", bus.bvalid, bus.rvalid);
    end
    bus.awaddr = 12'h008; bus.wdata = 32'h3; bus.wstrb = 4'hF; bus.awvalid = 1; bus.wvalid = 1;
    #1;
    n_tests++;
    if (bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
      n_fail++; $display("FAIL abort_ready awready=%b wready=%b want 0/0", bus.awready, bus.wready);
    end
    @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    reset = 0;
    model_reset();
    n_tests++;
    if (bus.bvalid !== 1'b0 || glb_stall !== 4'hF) begin
      n_fail++; $display("FAIL abort_nowrite bvalid=%b stall=%h want 0/f", bus.bvalid, glb_stall);
    end
    @(posedge clk); #1;
    check_read("abort_scratch", 12'h004);
    check_read("abort_stall", 12'h008);
  endtask

  initial begin
    bus.awaddr = 0; bus.awprot = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_id_stall();
    test_scratch_strobe();
    test_unmapped();
    test_backpressure();
    test_irq();
    test_start();
    test_concurrent();
    test_random();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
